// File: rtl/rsh_pkg.sv
// Shared definitions for the sequential right shifter.
// Holds mode codes, FSM state encoding and default widths.
package rsh_pkg;

    localparam int RSH_WIDTH = 16;
    localparam int RSH_SHW   = 4;

    localparam logic [1:0] MODE_SRL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } rsh_state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit right step (SRL / SRA / ROR).
// Ports: value (in), mode (in), stepped (out); mode 2'b11 acts as SRL.
module shift_step
    import rsh_pkg::*;
#(
    parameter int WIDTH = RSH_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] stepped
);

    always_comb begin
        stepped = {1'b0, value[WIDTH-1:1]};
        unique case (1'b1)
            (mode == MODE_SRA):
                stepped = {value[WIDTH-1], value[WIDTH-1:1]};
            (mode == MODE_ROR):
                stepped = {value[0], value[WIDTH-1:1]};
            default:
                stepped = {1'b0, value[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/seq_right_shifter.sv
// Multi-cycle right shift/rotate unit, one bit position per clock.
// Ports: clk, rst, start, Ip, shift_mag, mode -> busy, done, Op.
module seq_right_shifter
    import rsh_pkg::*;
#(
    parameter int WIDTH = RSH_WIDTH,
    parameter int SHW   = RSH_SHW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Ip,
    input  logic [SHW-1:0]   shift_mag,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Op
);

    rsh_state_t       state;
    logic [SHW-1:0]   count;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] op_next;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .value   (Op),
        .mode    (mode_q),
        .stepped (op_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            Op     <= '0;
            count  <= '0;
            mode_q <= MODE_SRL;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    // Accepting in DONE gives back-to-back issue.
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        Op     <= Ip;
                        count  <= shift_mag;
                        mode_q <= mode;
                        if (shift_mag != '0) begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    Op    <= op_next;
                    count <= count - 1'b1;
                    if (count == SHW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed self-checking bench for seq_right_shifter.
// Drives ops, checks results, latency, busy length and pulses.
module tb_seq_right_shifter;
    import rsh_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] Ip;
    logic [3:0]  shift_mag;
    logic [1:0]  mode;
    logic        busy;
    logic        done;
    logic [15:0] Op;

    int n_checks = 0;
    int n_pass   = 0;

    seq_right_shifter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .Ip        (Ip),
        .shift_mag (shift_mag),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .Op        (Op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drive a start across one edge; returns at accept edge + 1.
    task automatic launch(input logic [15:0] ip,
                          input logic [3:0] mag,
                          input logic [1:0] md);
        start     = 1'b1;
        Ip        = ip;
        shift_mag = mag;
        mode      = md;
        @(posedge clk); #1;
        start     = 1'b0;
        Ip        = 16'hDEAD;
        shift_mag = 4'hA;
        mode      = MODE_ROR;
    endtask

    // lat = 1 at accept edge + 1, then +1 per edge until done.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input string tag,
                          input logic [15:0] ip,
                          input logic [3:0] mag,
                          input logic [1:0] md,
                          input logic [15:0] exp_op,
                          input int exp_lat,
                          input int exp_busy);
        int lat, bc;
        launch(ip, mag, md);
        wait_done(lat, bc);
        check({tag, "_op"}, 32'(Op), 32'(exp_op));
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, bc, exp_busy);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(done), 0);
        check({tag, "_hold"}, 32'(Op), 32'(exp_op));
    endtask

    initial begin
        int lat, bc, ndone;
        rst = 1'b1; start = 1'b0;
        Ip = '0; shift_mag = '0; mode = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_op", 32'(Op), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // reset in the middle of a shift
        launch(16'hB2C4, 4'd8, MODE_SRL);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_op", 32'(Op), 0);
        rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("mid_rst_nodone", ndone, 0);

        run_op("srl4", 16'hB2C4, 4'd4, MODE_SRL, 16'h0B2C, 5, 4);
        run_op("sra4", 16'hB2C4, 4'd4, MODE_SRA, 16'hFB2C, 5, 4);
        run_op("ror4", 16'hB2C4, 4'd4, MODE_ROR, 16'h4B2C, 5, 4);
        run_op("ror0", 16'hB2C4, 4'd0, MODE_ROR, 16'hB2C4, 1, 0);
        run_op("sra15", 16'h8000, 4'd15, MODE_SRA, 16'hFFFF, 16, 15);
        run_op("srl15", 16'h8000, 4'd15, MODE_SRL, 16'h0001, 16, 15);
        run_op("ror15", 16'h8000, 4'd15, MODE_ROR, 16'h0001, 16, 15);
        run_op("rsv4", 16'hB2C4, 4'd4, 2'b11, 16'h0B2C, 5, 4);

        // start while busy is ignored
        launch(16'hFFFF, 4'd8, MODE_SRL);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; Ip = 16'h1234;
        shift_mag = 4'd3; mode = MODE_ROR;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bc);
        check("busy_ign_op", 32'(Op), 32'h00FF);
        check("busy_ign_lat", lat + 3, 9);

        // back-to-back: start issued in the DONE cycle
        launch(16'h8000, 4'd1, MODE_SRA);
        check("b2b_done_low", 32'(done), 0);
        wait_done(lat, bc);
        check("b2b_op", 32'(Op), 32'hC000);
        check("b2b_lat", lat, 2);
        @(posedge clk); #1;
        check("b2b_pulse", 32'(done), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
